// File: rtl/pk_pkg.sv
// Shared definitions for the public-key stream buffer: controller states,
// default geometry and the packed row type used by loader and datapath.
package pk_pkg;

  localparam int DEFAULT_DATA_WIDTH = 12;
  localparam int DEFAULT_NUM_COLS   = 4;
  localparam int DEFAULT_SUM_WIDTH  = 16;
  localparam int DEFAULT_NUM_ROWS   = 1024;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SEALED = 2'd1,
    STREAM = 2'd2
  } pk_state_t;

  typedef logic [DEFAULT_NUM_COLS*DEFAULT_DATA_WIDTH-1:0] row_t;

endpackage

// File: rtl/pk_skid_buffer.sv
// Two-entry valid/ready output stage. Both the output slot and the skid slot
// are registered, so nothing upstream reaches the outputs combinationally.
// flush drops both entries but keeps the data registers as they are.
module pk_skid_buffer
  import pk_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;

  assign in_ready = !skid_valid;

  // Refill the output slot from the skid slot first, else from the input; park input in the skid slot while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) begin
          out_data <= in_data;
        end
      end
    end else if (in_valid && in_ready) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/public_key_stream_buffer.sv
// Replayable LWE public-key row store. Rows and their sums are loaded once,
// sealed, then streamed out any number of times with columns >= k zeroed.
// Optional feature macro: PUBLIC_KEY_STREAM_BUFFER_PARITY_EN adds one stored
// even-parity bit per row and a parity_err output flagging corrupted rows.
module public_key_stream_buffer
  import pk_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_COLS   = DEFAULT_NUM_COLS,
  parameter int NUM_ROWS   = DEFAULT_NUM_ROWS,
  parameter int SUM_WIDTH  = DEFAULT_SUM_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear,
  input  logic                             seal,
  input  logic                             start,
  input  logic [$clog2(NUM_COLS+1)-1:0]    k_sel,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [NUM_COLS*DATA_WIDTH-1:0]   s_data,
  input  logic [SUM_WIDTH-1:0]             s_sum,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [NUM_COLS*DATA_WIDTH-1:0]   m_data,
  output logic [SUM_WIDTH-1:0]             m_sum,
  output logic                             m_last,
`ifdef PUBLIC_KEY_STREAM_BUFFER_PARITY_EN
  output logic                             parity_err,
`endif
  output logic [$clog2(NUM_ROWS+1)-1:0]    row_count,
  output logic                             full,
  output logic                             empty,
  output logic                             err
);

  localparam int ROW_W = NUM_COLS * DATA_WIDTH;
  localparam int CW    = $clog2(NUM_ROWS + 1);
  localparam int AW    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int KW    = $clog2(NUM_COLS + 1);
`ifdef PUBLIC_KEY_STREAM_BUFFER_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int PAY_W = ROW_W + SUM_WIDTH + 1 + PAR_W;

  pk_state_t state, state_next;
  logic      err_next;

  logic [CW-1:0] rd_ptr;
  logic [CW-1:0] rd_idx;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wr_addr;
  logic [KW-1:0] k_reg;

  logic wr_fire, pop, k_ok, start_ok;
  logic issue_first, issue_stream, issue, rd_last;
  logic space_ok, skid_in_ready;
  logic [1:0] skid_count;

  logic [ROW_W-1:0]     data_mem [NUM_ROWS];
  logic [SUM_WIDTH-1:0] sum_mem  [NUM_ROWS];
  logic [ROW_W-1:0]     ram_data;
  logic [SUM_WIDTH-1:0] ram_sum;
  logic                 ram_valid;
  logic                 ram_last;
  logic [ROW_W-1:0]     masked_data;
  logic [PAY_W-1:0]     in_payload;
  logic [PAY_W-1:0]     out_payload;

  assign full    = (row_count == CW'(NUM_ROWS));
  assign empty   = (row_count == '0);
  assign s_ready = rst_n && (state == LOAD) && !full;
  assign wr_fire = s_valid && s_ready && !clear;
  assign wr_addr = row_count[AW-1:0];
  assign pop     = m_valid && m_ready;

  assign k_ok     = (k_sel != '0) && (k_sel <= KW'(NUM_COLS));
  assign start_ok = (state == SEALED) && start && k_ok;

  // A read is only issued when its result is guaranteed a slot in the output stage one cycle later.
  assign skid_count   = {1'b0, m_valid} + {1'b0, ~skid_in_ready};
  assign space_ok     = (skid_count + {1'b0, ram_valid}) <= (2'd1 + {1'b0, pop});
  assign issue_first  = start_ok && !clear;
  assign issue_stream = (state == STREAM) && (rd_ptr < row_count) && space_ok && !clear;
  assign issue        = issue_first || issue_stream;
  assign rd_idx       = issue_first ? '0 : rd_ptr;
  assign rd_addr      = rd_idx[AW-1:0];
  assign rd_last      = (rd_idx == row_count - 1'b1);

  // Command decode: legal seal/start move the controller, anything else raises an error pulse; clear wins over all.
  always_comb begin
    state_next = state;
    err_next   = 1'b0;
    case (state)
      LOAD: begin
        if (seal) begin
          if ((row_count != '0) || wr_fire) state_next = SEALED;
          else                              err_next   = 1'b1;
        end
        if (start) err_next = 1'b1;
      end
      SEALED: begin
        if (seal) err_next = 1'b1;
        if (start) begin
          if (k_ok) state_next = STREAM;
          else      err_next   = 1'b1;
        end
      end
      STREAM: begin
        if (seal || start) err_next = 1'b1;
        if (pop && m_last) state_next = SEALED;
      end
      default: state_next = LOAD;
    endcase
    if (clear) begin
      state_next = LOAD;
      err_next   = 1'b0;
    end
  end

  // Controller state, error pulse, pointers and the latched column count.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state     <= LOAD;
      err       <= 1'b0;
      row_count <= '0;
      rd_ptr    <= '0;
      ram_valid <= 1'b0;
      ram_last  <= 1'b0;
      if (!rst_n) k_reg <= '0;
    end else begin
      state     <= state_next;
      err       <= err_next;
      ram_valid <= issue;
      if (wr_fire) row_count <= row_count + 1'b1;
      if (issue) begin
        rd_ptr   <= rd_idx + 1'b1;
        ram_last <= rd_last;
      end
      if (start_ok) k_reg <= k_sel;
    end
  end

  // Key storage: write at the load pointer, registered read feeding the output stage.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      data_mem[wr_addr] <= s_data;
      sum_mem[wr_addr]  <= s_sum;
    end
    if (issue) begin
      ram_data <= data_mem[rd_addr];
      ram_sum  <= sum_mem[rd_addr];
    end
  end

  // Zero every column at or beyond the k latched when the pass started.
  always_comb begin
    masked_data = ram_data;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (c >= int'(k_reg)) masked_data[c*DATA_WIDTH +: DATA_WIDTH] = '0;
    end
  end

`ifdef PUBLIC_KEY_STREAM_BUFFER_PARITY_EN
  logic par_mem [NUM_ROWS];
  logic ram_par;
  logic parity_bad;

  // Parity is computed over the unmasked row and sum so it checks exactly what was written.
  always_ff @(posedge clk) begin
    if (wr_fire) par_mem[wr_addr] <= ^{s_data, s_sum};
    if (issue)   ram_par <= par_mem[rd_addr];
  end

  assign parity_bad = ram_par ^ (^{ram_data, ram_sum});
  assign in_payload = {parity_bad, ram_last, ram_sum, masked_data};
  assign parity_err = m_valid && out_payload[ROW_W+SUM_WIDTH+1];
`else
  assign in_payload = {ram_last, ram_sum, masked_data};
`endif

  pk_skid_buffer #(.WIDTH(PAY_W)) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (clear),
    .in_valid  (ram_valid),
    .in_ready  (skid_in_ready),
    .in_data   (in_payload),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .out_data  (out_payload)
  );

  assign m_data = out_payload[ROW_W-1:0];
  assign m_sum  = out_payload[ROW_W +: SUM_WIDTH];
  assign m_last = out_payload[ROW_W+SUM_WIDTH];

endmodule

// File: tb/tb_public_key_stream_buffer.sv
// Scoreboard bench for public_key_stream_buffer: stimulus pushes expected rows
// from a queue-based key model, a negedge monitor pops and compares them.
module tb_public_key_stream_buffer;
  import pk_pkg::*;

  localparam int DW = 12;
  localparam int NC = 4;
  localparam int NR = 64;
  localparam int SW = 16;
  localparam int KW = $clog2(NC + 1);
  localparam int CW = $clog2(NR + 1);

  typedef logic [NC*DW+SW:0] exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          seal = 1'b0;
  logic          start = 1'b0;
  logic [KW-1:0] k_sel = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  row_t          s_data = '0;
  logic [SW-1:0] s_sum = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  row_t          m_data;
  logic [SW-1:0] m_sum;
  logic          m_last;
  logic [CW-1:0] row_count;
  logic          full;
  logic          empty;
  logic          err;
`ifdef PUBLIC_KEY_STREAM_BUFFER_PARITY_EN
  logic          parity_err;
`endif

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  row_t key_data[$];
  logic [SW-1:0] key_sum[$];
  logic prev_stall = 1'b0;
  exp_t prev_out = '0;

  public_key_stream_buffer #(
    .DATA_WIDTH(DW), .NUM_COLS(NC), .NUM_ROWS(NR), .SUM_WIDTH(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .seal(seal), .start(start),
    .k_sel(k_sel), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_sum(s_sum), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sum(m_sum), .m_last(m_last),
`ifdef PUBLIC_KEY_STREAM_BUFFER_PARITY_EN
    .parity_err(parity_err),
`endif
    .row_count(row_count), .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic row_t randRow();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[NC*DW-1:0];
  endfunction

  function automatic logic [SW-1:0] randSum();
    logic [31:0] t;
    t = $urandom();
    return t[SW-1:0];
  endfunction

  // Expected output of one pass: every stored row in order, columns >= k zero, last flag on the final row.
  task automatic modelPass(input int k);
    row_t masked;
    for (int i = 0; i < key_data.size(); i++) begin
      masked = key_data[i];
      for (int c = 0; c < NC; c++) if (c >= k) masked[c*DW +: DW] = '0;
      exp_q.push_back({masked, key_sum[i], (i == key_data.size() - 1)});
    end
  endtask

  task automatic modelClear();
    exp_q.delete();
    key_data.delete();
    key_sum.delete();
  endtask

  task automatic applyStimulus(input row_t d, input logic [SW-1:0] sm, input logic doSeal);
    s_valid = 1'b1;
    s_data  = d;
    s_sum   = sm;
    seal    = doSeal;
    if (key_data.size() < NR) begin
      key_data.push_back(d);
      key_sum.push_back(sm);
    end
    tick();
    s_valid = 1'b0;
    seal    = 1'b0;
  endtask

  task automatic startPass(input int k);
    k_sel = KW'(k);
    start = 1'b1;
    modelPass(k);
    tick();
    start = 1'b0;
  endtask

  task automatic pulseCommand(input string name, input logic doSeal, input logic doStart, input int k);
    seal  = doSeal;
    start = doStart;
    k_sel = KW'(k);
    tick();
    seal  = 1'b0;
    start = 1'b0;
    sample();
    checkOutput({name, "_err"}, err, 1'b1);
    tick();
    sample();
    checkOutput({name, "_err_one_cycle"}, err, 1'b0);
    tick();
  endtask

  task automatic waitDrain(input string name, input int budget, input logic rnd);
    int cyc;
    logic [31:0] r;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      r = $urandom();
      if (rnd) m_ready = r[0];
      k_sel = r[KW:1];
      tick();
      cyc++;
    end
    m_ready = 1'b1;
    checkOutput({name, "_drained"}, exp_q.size(), 0);
    tick();
    tick();
    tick();
    sample();
    checkOutput({name, "_idle_after"}, m_valid, 1'b0);
    tick();
  endtask

  // Monitor: compare every accepted row with the scoreboard and hold stalled outputs steady.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) checkOutput("stall_hold", {m_valid, m_data, m_sum, m_last}, {1'b1, prev_out});
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_row: got %0h expected none", {m_data, m_sum, m_last});
        end else begin
          e = exp_q.pop_front();
          checkOutput("row", {m_data, m_sum, m_last}, e);
        end
      end
`ifdef PUBLIC_KEY_STREAM_BUFFER_PARITY_EN
      if (m_valid) checkOutput("parity_err", parity_err, 1'b0);
`endif
      prev_stall = m_valid && !m_ready && !clear;
      prev_out   = {m_data, m_sum, m_last};
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tick();
    tick();
    sample();
    checkOutput("reset_s_ready", s_ready, 1'b0);
    checkOutput("reset_outputs", {m_valid, m_data, m_sum, m_last}, '0);
    checkOutput("reset_status", {row_count, full, empty, err}, {CW'(0), 1'b0, 1'b1, 1'b0});
    tick();
    rst_n = 1'b1;
    sample();
    checkOutput("release_s_ready", s_ready, 1'b1);
    tick();

    // Five patterned rows, the last one written together with seal.
    for (int i = 0; i < 5; i++)
      applyStimulus({DW'(i + 3), DW'(i + 2), DW'(i + 1), DW'(i)}, SW'(100 + i), (i == 4));
    sample();
    checkOutput("load5_count", {row_count, empty, s_ready}, {CW'(5), 1'b0, 1'b0});
    tick();

    // Full-width pass: latency, no bubbles, then idle.
    m_ready = 1'b1;
    startPass(4);
    sample();
    checkOutput("first_valid_c1", m_valid, 1'b0);
    tick();
    sample();
    checkOutput("first_valid_c2", m_valid, 1'b1);
    for (int j = 0; j < 4; j++) begin
      tick();
      sample();
      checkOutput("no_bubble", m_valid, 1'b1);
    end
    tick();
    sample();
    checkOutput("pass1_end_valid", m_valid, 1'b0);
    tick();
    checkOutput("pass1_drained", exp_q.size(), 0);

    // Rejected commands while sealed.
    pulseCommand("start_k0", 1'b0, 1'b1, 0);
    pulseCommand("start_k5", 1'b0, 1'b1, 5);
    pulseCommand("seal_sealed", 1'b1, 1'b0, 4);
    sample();
    checkOutput("sealed_hold", {m_valid, s_ready, row_count}, {1'b0, 1'b0, CW'(5)});
    tick();

    // Replays with narrower k.
    startPass(3);
    waitDrain("pass_k3", 50, 1'b0);
    startPass(2);
    waitDrain("pass_k2", 50, 1'b0);

    // Clear while row 3 is being handed over.
    startPass(4);
    repeat (4) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    sample();
    checkOutput("clear_status", {m_valid, row_count, s_ready, empty}, {1'b0, CW'(0), 1'b1, 1'b1});
    modelClear();
    tick();
    tick();
    sample();
    checkOutput("clear_flushed", m_valid, 1'b0);
    tick();

    // Rejected commands while loading an empty key.
    pulseCommand("seal_empty", 1'b1, 1'b0, 4);
    pulseCommand("start_load", 1'b0, 1'b1, 4);
    sample();
    checkOutput("load_hold", {s_ready, row_count}, {1'b1, CW'(0)});
    tick();

    // Reload two rows and stream only those.
    applyStimulus(randRow(), randSum(), 1'b0);
    applyStimulus(randRow(), randSum(), 1'b0);
    seal = 1'b1;
    tick();
    seal = 1'b0;
    sample();
    checkOutput("reload_status", {s_ready, row_count}, {1'b0, CW'(2)});
    tick();
    startPass(4);
    waitDrain("reload_pass", 50, 1'b0);

    // Fill beyond capacity with s_valid held.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    modelClear();
    for (int i = 0; i < NR + 6; i++) applyStimulus(randRow(), randSum(), 1'b0);
    sample();
    checkOutput("fill_status", {row_count, full, s_ready, empty}, {CW'(NR), 1'b1, 1'b0, 1'b0});
    tick();
    seal = 1'b1;
    tick();
    seal = 1'b0;

    // Random back-pressure pass with a rejected start mid-pass.
    m_ready = 1'b0;
    startPass($urandom_range(1, NC));
    m_ready = 1'b0;
    tick();
    tick();
    k_sel = KW'(4);
    start = 1'b1;
    tick();
    start = 1'b0;
    sample();
    checkOutput("start_stream_err", err, 1'b1);
    tick();
    waitDrain("random_pass", 3000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
